hilo_div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider that owns the architectural HI/LO registers.
- Sits in EX, beside the ALU. It is driven by the decoder's div and mf[1:0] controls: mf 2'b10 selects MFHI, mf 2'b11 selects MFLO.
- Generalises the single-cycle DIV/MFHI/MFLO path to a parametrised width and iterations-per-cycle, and adds signed/unsigned mode, a divide-by-zero flag, flush and a pipeline-stall interlock.

---
 rtl/hilo_div_unit_pkg.sv | 17 +
 rtl/hilo_div_unit_div_step.sv | 27 ++
 rtl/hilo_div_unit.sv | 171 +++++++++++++++++
 tb/tb_hilo_div_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO divide unit: default width, MF read
// encodings and the divider state encoding.
package hilo_div_unit_pkg;

  localparam int DEF_WIDTH = 32;

  // Decoder mf[1:0] encodings for the move-from instructions.
  localparam logic [1:0] MF_HI = 2'b10;
  localparam logic [1:0] MF_LO = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

endpackage : hilo_div_unit_pkg

// File: rtl/hilo_div_unit_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the next
// dividend bit into the partial remainder, trial-subtract the divisor and
// keep the difference only when it does not go negative.
module hilo_div_unit_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;

  // The extra top bit of the subtraction is the borrow that decides the
  // quotient bit; the partial remainder itself never needs more than WIDTH+1.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_shift - {2'b00, i_dvsr};
  assign w_ge    = ~w_diff[WIDTH+1];

  assign o_rem = w_ge ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule : hilo_div_unit_div_step

// File: rtl/hilo_div_unit.sv
// Multi-cycle radix-2 restoring divider owning the architectural HI/LO
// registers. STEPS iterations are chained per clock; a final FIX cycle
// applies sign correction and the divide-by-zero result before writing HI/LO.
module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEPS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_b,
  input  logic             i_div_start,
  input  logic             i_div_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_flush,
  input  logic [1:0]       i_mf,
  output logic [WIDTH-1:0] o_mf_data,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int ITERS = WIDTH / STEPS;
  localparam int CW    = $clog2(ITERS) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;

  logic [CW-1:0]    r_count;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_dividend_raw;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_zero_dvsr;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_div_by_zero;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  // Operand magnitudes; in signed mode negative inputs are two's-complemented.
  // MIN stays MIN, which reads correctly as the unsigned magnitude 2^(WIDTH-1).
  assign w_a_neg = i_div_signed & i_dividend[WIDTH-1];
  assign w_b_neg = i_div_signed & i_divisor[WIDTH-1];
  assign w_mag_a = w_a_neg ? (WIDTH'(0) - i_dividend) : i_dividend;
  assign w_mag_b = w_b_neg ? (WIDTH'(0) - i_divisor)  : i_divisor;

  // Chain of STEPS single-bit iterations evaluated within one clock.
  logic [WIDTH:0]   w_rem_chain [0:STEPS];
  logic [WIDTH-1:0] w_quo_chain [0:STEPS];

  assign w_rem_chain[0] = r_rem;
  assign w_quo_chain[0] = r_quo;

  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
      hilo_div_unit_div_step #(
        .WIDTH (WIDTH)
      ) u_div_step (
        .i_rem  (w_rem_chain[gi]),
        .i_quo  (w_quo_chain[gi]),
        .i_dvsr (r_dvsr),
        .o_rem  (w_rem_chain[gi+1]),
        .o_quo  (w_quo_chain[gi+1])
      );
    end
  endgenerate

  // Sign correction; MIN / -1 falls out naturally (magnitude quotient is
  // 2^(WIDTH-1), not negated, remainder 0). Divide-by-zero overrides both.
  assign w_rem_mag = r_rem[WIDTH-1:0];
  assign w_fix_lo  = r_zero_dvsr ? {WIDTH{1'b1}} :
                     (r_q_neg ? (WIDTH'(0) - r_quo) : r_quo);
  assign w_fix_hi  = r_zero_dvsr ? r_dividend_raw :
                     (r_r_neg ? (WIDTH'(0) - w_rem_mag) : w_rem_mag);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush overrides everything, including a new request.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    if (i_flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_div_start) begin
            w_state_next = CALC;
            w_accept     = 1'b1;
          end
        end
        CALC: begin
          if (r_count == LAST_CNT) begin
            w_state_next = FIX;
          end
        end
        FIX: begin
          w_state_next = IDLE;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // Datapath: latch operands on accept, iterate in CALC, commit HI/LO in FIX.
  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_count        <= '0;
      r_rem          <= '0;
      r_quo          <= '0;
      r_dvsr         <= '0;
      r_dividend_raw <= '0;
      r_q_neg        <= 1'b0;
      r_r_neg        <= 1'b0;
      r_zero_dvsr    <= 1'b0;
      r_hi           <= '0;
      r_lo           <= '0;
      r_div_by_zero  <= 1'b0;
    end else if (w_accept) begin
      r_count        <= '0;
      r_rem          <= '0;
      r_quo          <= w_mag_a;
      r_dvsr         <= w_mag_b;
      r_dividend_raw <= i_dividend;
      r_q_neg        <= w_a_neg ^ w_b_neg;
      r_r_neg        <= w_a_neg;
      r_zero_dvsr    <= (i_divisor == '0);
      r_div_by_zero  <= 1'b0;
    end else if (!i_flush && r_state == CALC) begin
      r_rem   <= w_rem_chain[STEPS];
      r_quo   <= w_quo_chain[STEPS];
      r_count <= r_count + 1'b1;
    end else if (!i_flush && r_state == FIX) begin
      r_lo          <= w_fix_lo;
      r_hi          <= w_fix_hi;
      r_div_by_zero <= r_zero_dvsr;
    end
  end

  assign o_busy        = (r_state != IDLE);
  assign o_stall       = o_busy & (i_div_start | i_mf[1]);
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_div_by_zero = r_div_by_zero;
  assign o_mf_data     = (i_mf == MF_HI) ? r_hi :
                         (i_mf == MF_LO) ? r_lo : '0;

endmodule : hilo_div_unit

// File: tb/tb_hilo_div_unit.sv
// Directed bench: one STEPS=1 and one STEPS=4 divider share the stimulus
// (separate resets) and are checked against hand-computed results.
module tb_hilo_div_unit;

  logic        clk = 1'b0;
  logic        rst_b1, rst_b4;
  logic        div_start, div_signed, flush;
  logic [31:0] dividend, divisor;
  logic [1:0]  mf;

  logic [31:0] mf_data1, hi1, lo1, mf_data4, hi4, lo4;
  logic        stall1, busy1, dbz1, stall4, busy4, dbz4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hilo_div_unit #(.WIDTH(32), .STEPS(1)) u_dut1 (
    .i_clk(clk), .i_rst_b(rst_b1), .i_div_start(div_start), .i_div_signed(div_signed),
    .i_dividend(dividend), .i_divisor(divisor), .i_flush(flush), .i_mf(mf),
    .o_mf_data(mf_data1), .o_stall(stall1), .o_busy(busy1), .o_div_by_zero(dbz1),
    .o_hi(hi1), .o_lo(lo1)
  );

  hilo_div_unit #(.WIDTH(32), .STEPS(4)) u_dut4 (
    .i_clk(clk), .i_rst_b(rst_b4), .i_div_start(div_start), .i_div_signed(div_signed),
    .i_dividend(dividend), .i_divisor(divisor), .i_flush(flush), .i_mf(mf),
    .o_mf_data(mf_data4), .o_stall(stall4), .o_busy(busy4), .o_div_by_zero(dbz4),
    .o_hi(hi4), .o_lo(lo4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request during T0; returns positioned in T1.
  task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    div_start  = 1'b1;
    tick();
    div_start  = 1'b0;
  endtask

  // Full divide on both units: STEPS=4 done at T10, STEPS=1 done at T34.
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input logic exp_dbz);
    start_div(sgn, a, b);
    for (int t = 1; t <= 34; t++) begin
      if (t == 1) begin
        chk({name, " busy1@T1"}, {31'd0, busy1}, 32'd1);
        chk({name, " busy4@T1"}, {31'd0, busy4}, 32'd1);
        chk({name, " dbz_clr@T1"}, {31'd0, dbz1}, 32'd0);
      end
      if (t == 9)  chk({name, " busy4@T9"}, {31'd0, busy4}, 32'd1);
      if (t == 10) begin
        chk({name, " busy4@T10"}, {31'd0, busy4}, 32'd0);
        chk({name, " lo4"}, lo4, exp_lo);
        chk({name, " hi4"}, hi4, exp_hi);
        chk({name, " dbz4"}, {31'd0, dbz4}, {31'd0, exp_dbz});
      end
      if (t == 33) chk({name, " busy1@T33"}, {31'd0, busy1}, 32'd1);
      if (t == 34) begin
        chk({name, " busy1@T34"}, {31'd0, busy1}, 32'd0);
        chk({name, " lo1"}, lo1, exp_lo);
        chk({name, " hi1"}, hi1, exp_hi);
        chk({name, " dbz1"}, {31'd0, dbz1}, {31'd0, exp_dbz});
        mf = 2'b11; #1;
        chk({name, " mflo"}, mf_data1, exp_lo);
        chk({name, " stall_mflo"}, {31'd0, stall1}, 32'd0);
        mf = 2'b10; #1;
        chk({name, " mfhi"}, mf_data1, exp_hi);
        mf = 2'b00; #1;
        chk({name, " mf_none"}, mf_data1, 32'd0);
      end
      if (t < 34) tick();
    end
    $display("div %s: %0s 0x%08h / 0x%08h -> lo=0x%08h hi=0x%08h dbz=%0d",
             name, sgn ? "signed" : "unsigned", a, b, lo1, hi1, dbz1);
  endtask

  initial begin
    rst_b1 = 1'b0; rst_b4 = 1'b0;
    div_start = 1'b0; div_signed = 1'b0; flush = 1'b0;
    dividend = '0; divisor = '0; mf = 2'b00;
    tick(); tick();
    rst_b1 = 1'b1; rst_b4 = 1'b1;

    // Reset state.
    chk("rst busy1", {31'd0, busy1}, 32'd0);
    chk("rst hi1", hi1, 32'd0);
    chk("rst lo1", lo1, 32'd0);
    chk("rst dbz1", {31'd0, dbz1}, 32'd0);
    chk("rst busy4", {31'd0, busy4}, 32'd0);
    mf = 2'b11; #1;
    chk("rst mflo", mf_data1, 32'd0);
    chk("rst stall", {31'd0, stall1}, 32'd0);
    mf = 2'b00;
    $display("reset: busy=%0d hi=0x%08h lo=0x%08h", busy1, hi1, lo1);
    tick();

    run_div("u100/7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    run_div("s-7/2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
    run_div("uF9/2",    1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0);
    run_div("u5/0",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1);
    run_div("u9/3",     1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0);
    run_div("sMIN/-1",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
    tick();

    // Back-to-back: second DIV plus MFLO raised at T5, held until accepted at T34.
    start_div(1'b0, 32'd100, 32'd7);
    for (int t = 1; t <= 68; t++) begin
      if (t == 5) begin
        div_start = 1'b1; dividend = 32'd9; divisor = 32'd3; mf = 2'b11; #1;
        chk("b2b stall@T5", {31'd0, stall1}, 32'd1);
      end
      if (t == 33) chk("b2b stall@T33", {31'd0, stall1}, 32'd1);
      if (t == 34) begin
        chk("b2b stall@T34", {31'd0, stall1}, 32'd0);
        chk("b2b mflo@T34", mf_data1, 32'd14);
      end
      if (t == 35) begin
        div_start = 1'b0; mf = 2'b00; #1;
        chk("b2b busy@T35", {31'd0, busy1}, 32'd1);
      end
      if (t == 68) begin
        chk("b2b lo", lo1, 32'd3);
        chk("b2b hi", hi1, 32'd0);
        chk("b2b busy@T68", {31'd0, busy1}, 32'd0);
      end
      tick();
    end
    $display("b2b: 100/7 then 9/3 -> lo=0x%08h hi=0x%08h", lo1, hi1);

    // Flush at T10 of a divide; then flush together with a request in IDLE.
    start_div(1'b0, 32'd100, 32'd7);
    for (int t = 1; t <= 13; t++) begin
      if (t == 10) begin
        flush = 1'b1; div_start = 1'b1; mf = 2'b11; #1;
        chk("flush stall@T10", {31'd0, stall1}, 32'd1);
      end
      if (t == 11) begin
        flush = 1'b0; div_start = 1'b0; #1;
        chk("flush busy@T11", {31'd0, busy1}, 32'd0);
        chk("flush stall@T11", {31'd0, stall1}, 32'd0);
        chk("flush lo kept", lo1, 32'd3);
        chk("flush hi kept", hi1, 32'd0);
        chk("flush mflo", mf_data1, 32'd3);
        mf = 2'b00;
      end
      if (t == 12) begin
        flush = 1'b1; div_start = 1'b1;
      end
      if (t == 13) begin
        flush = 1'b0; div_start = 1'b0; #1;
        chk("flush+start busy1", {31'd0, busy1}, 32'd0);
        chk("flush+start busy4", {31'd0, busy4}, 32'd0);
      end
      tick();
    end
    $display("flush: busy=%0d lo=0x%08h hi=0x%08h", busy1, lo1, hi1);

    // Reset of the STEPS=4 unit at T4 of a divide.
    start_div(1'b0, 32'd9, 32'd3);
    for (int t = 1; t <= 5; t++) begin
      if (t == 4) begin
        chk("rst4 pre lo", lo4, 32'd14);
        chk("rst4 pre hi", hi4, 32'd2);
        chk("rst4 pre busy", {31'd0, busy4}, 32'd1);
        rst_b4 = 1'b0;
      end
      if (t == 5) begin
        rst_b4 = 1'b1;
        chk("rst4 lo", lo4, 32'd0);
        chk("rst4 hi", hi4, 32'd0);
        chk("rst4 busy", {31'd0, busy4}, 32'd0);
      end
      if (t < 5) tick();
    end
    $display("reset mid-divide: busy4=%0d hi4=0x%08h lo4=0x%08h", busy4, hi4, lo4);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hilo_div_unit
